// File: rtl/fetch_stage.sv
// Instruction fetch stage. Holds the PC and the IF/ID pipeline register.
// In RUN it requests imem every cycle and advances on ihit. A decoded halt
// parks the stage in HALTED, and only reset leaves that state.
module fetch_stage #(
  parameter logic [31:0] PC_INIT   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] pc_target,
  input  logic        halt,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] npc_out,
  output logic        valid
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t      state_r, state_n;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halt_go;

  // A halt only counts when it belongs to a real instruction and no redirect kills it.
  assign halt_go  = (state_r == RUN) && halt && valid && !flush;
  // The 32-bit add wraps naturally at the top of the address space.
  assign pc_plus4 = pc + 32'd4;
  assign imemaddr = pc;

  // State register.
  always_ff @(posedge CLK) begin
    if (!nRST) state_r <= RUN;
    else       state_r <= state_n;
  end

  // Next-state logic: HALTED is sticky until reset.
  always_comb begin
    state_n = state_r;
    if (halt_go) state_n = HALTED;
  end

  // Output logic: the fetch request drops while halted.
  always_comb begin
    imemREN = 1'b0;
    if (state_r == RUN) imemREN = 1'b1;
  end

  // PC and IF/ID register. Priority: flush > halt > stall > ihit > miss.
  // A bubble keeps pc_out/npc_out so the last fetched PC stays visible.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      pc      <= PC_INIT;
      instr   <= NOP_INSTR;
      pc_out  <= 32'd0;
      npc_out <= 32'd0;
      valid   <= 1'b0;
    end else if (state_r == RUN) begin
      if (flush) begin
        pc    <= {pc_target[31:2], 2'b00};
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end else if (halt_go) begin
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end else if (stall) begin
        // Hold everything; a concurrent ihit is dropped and refetched later.
      end else if (ihit) begin
        instr   <= imemload;
        pc_out  <= pc;
        npc_out <= pc_plus4;
        valid   <= 1'b1;
        pc      <= pc_plus4;
      end else begin
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: fetch, miss, stall, flush, halt, reset and
// PC wrap. A second instance starts at the top of the address space.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, stall, flush, halt;
  logic [31:0] imemload, pc_target;
  logic        imemREN;
  logic [31:0] imemaddr, instr, pc_out, npc_out;
  logic        valid;

  logic        w_ihit, w_zero;
  logic [31:0] w_load, w_zero32;
  logic        w_imemREN, w_valid;
  logic [31:0] w_imemaddr, w_instr, w_pc_out, w_npc_out;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  fetch_stage dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall), .flush(flush),
    .pc_target(pc_target), .halt(halt), .instr(instr), .pc_out(pc_out),
    .npc_out(npc_out), .valid(valid)
  );

  fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) u_wrap (
    .CLK(CLK), .nRST(nRST), .ihit(w_ihit), .imemload(w_load),
    .imemREN(w_imemREN), .imemaddr(w_imemaddr), .stall(w_zero), .flush(w_zero),
    .pc_target(w_zero32), .halt(w_zero), .instr(w_instr), .pc_out(w_pc_out),
    .npc_out(w_npc_out), .valid(w_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] e_instr,
                          input logic [31:0] e_pc, input logic e_valid);
    chk({tag, ".instr"}, instr, e_instr);
    chk({tag, ".pc_out"}, pc_out, e_pc);
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b1; stall = 1'b1; flush = 1'b1; halt = 1'b1;
    imemload = 32'hDEAD_BEEF; pc_target = 32'h0000_0040;
    w_ihit = 1'b0; w_zero = 1'b0; w_load = 32'h0; w_zero32 = 32'h0;

    // Reset overrides every other input.
    step; step;
    chk_ifid("rst", NOP, 32'h0, 1'b0);
    chk("rst.npc_out", npc_out, 32'h0);
    chk("rst.imemaddr", imemaddr, 32'h0);
    chk("rst.imemREN", {31'd0, imemREN}, 32'd1);

    // Halt with valid=0 must not stop the stage.
    nRST = 1'b1; ihit = 1'b0; stall = 1'b0; flush = 1'b0; halt = 1'b1;
    step;
    chk("nohalt.imemREN", {31'd0, imemREN}, 32'd1);
    chk_ifid("nohalt", NOP, 32'h0, 1'b0);
    halt = 1'b0;

    // Back-to-back hits.
    chk("hit0.imemaddr", imemaddr, 32'h0);
    ihit = 1'b1; imemload = 32'h00A0_0093;
    step;
    chk_ifid("hit0", 32'h00A0_0093, 32'h0, 1'b1);
    chk("hit0.npc_out", npc_out, 32'h4);
    chk("hit0.imemaddr", imemaddr, 32'h4);
    imemload = 32'h0010_0113;
    step;
    chk_ifid("hit1", 32'h0010_0113, 32'h4, 1'b1);
    chk("hit1.npc_out", npc_out, 32'h8);
    chk("hit1.imemaddr", imemaddr, 32'h8);

    // Three misses at PC=8: bubbles, PC holds, request stays up.
    ihit = 1'b0; imemload = 32'hBAD0_0000;
    for (int i = 0; i < 3; i++) begin
      step;
      chk_ifid("miss", NOP, 32'h4, 1'b0);
      chk("miss.imemaddr", imemaddr, 32'h8);
      chk("miss.imemREN", {31'd0, imemREN}, 32'd1);
    end

    // Stall with ihit: IF/ID and PC frozen, the hit is discarded.
    stall = 1'b1; ihit = 1'b1; imemload = 32'hBAD0_0001;
    for (int i = 0; i < 2; i++) begin
      step;
      chk_ifid("stall", NOP, 32'h4, 1'b0);
      chk("stall.imemaddr", imemaddr, 32'h8);
    end
    stall = 1'b0; imemload = 32'h0020_8193;
    step;
    chk_ifid("resume", 32'h0020_8193, 32'h8, 1'b1);
    chk("resume.npc_out", npc_out, 32'hC);
    chk("resume.imemaddr", imemaddr, 32'hC);

    // Flush beats stall, ihit and halt; the target is word-aligned.
    flush = 1'b1; stall = 1'b1; halt = 1'b1; pc_target = 32'h0000_0103;
    imemload = 32'hBAD0_0002;
    step;
    chk_ifid("flush", NOP, 32'h8, 1'b0);
    chk("flush.imemaddr", imemaddr, 32'h100);
    chk("flush.imemREN", {31'd0, imemREN}, 32'd1);
    flush = 1'b0; stall = 1'b0; halt = 1'b0;
    imemload = 32'h0000_006F;
    step;
    chk_ifid("tgt", 32'h0000_006F, 32'h100, 1'b1);
    chk("tgt.imemaddr", imemaddr, 32'h104);

    // Halt on a valid instruction: request drops, everything freezes.
    halt = 1'b1; imemload = 32'hBAD0_0003;
    step;
    chk("halt.imemREN", {31'd0, imemREN}, 32'd0);
    chk_ifid("halt", NOP, 32'h100, 1'b0);
    chk("halt.imemaddr", imemaddr, 32'h104);
    halt = 1'b0; pc_target = 32'h0000_0200;
    for (int i = 0; i < 10; i++) begin
      ihit = 1'b1; flush = i[0]; stall = i[1];
      step;
      chk("halted.imemaddr", imemaddr, 32'h104);
      chk("halted.imemREN", {31'd0, imemREN}, 32'd0);
      chk_ifid("halted", NOP, 32'h100, 1'b0);
    end

    // Reset leaves HALTED.
    flush = 1'b0; stall = 1'b0; ihit = 1'b0; nRST = 1'b0;
    step;
    chk("rst2.imemaddr", imemaddr, 32'h0);
    chk("rst2.imemREN", {31'd0, imemREN}, 32'd1);
    chk_ifid("rst2", NOP, 32'h0, 1'b0);
    chk("wrap.rst.imemaddr", w_imemaddr, 32'hFFFF_FFFC);
    nRST = 1'b1;
    step;
    chk("rst2.rel.imemREN", {31'd0, imemREN}, 32'd1);
    chk("rst2.rel.imemaddr", imemaddr, 32'h0);

    // PC+4 wraps at the top of the address space.
    w_ihit = 1'b1; w_load = 32'h0030_0213;
    step;
    chk("wrap.imemaddr", w_imemaddr, 32'h0);
    chk("wrap.npc_out", w_npc_out, 32'h0);
    chk("wrap.pc_out", w_pc_out, 32'hFFFF_FFFC);
    chk("wrap.instr", w_instr, 32'h0030_0213);
    chk("wrap.valid", {31'd0, w_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
